// File: rtl/sad_select_pkg.sv
// Shared constants for sad_select: candidate indices, compare order,
// FSM encoding and sub-pel bias multipliers.
package sad_select_pkg;

  localparam int N_CAND = 5;

  localparam logic [2:0] CAND_RH = 3'd0;
  localparam logic [2:0] CAND_RQ = 3'd1;
  localparam logic [2:0] CAND_F  = 3'd2;
  localparam logic [2:0] CAND_LQ = 3'd3;
  localparam logic [2:0] CAND_LH = 3'd4;

  // Step s of the minimum search visits the candidate in bits [3s+2:3s].
  localparam logic [14:0] CMP_ORDER = {CAND_LH, CAND_RH, CAND_LQ, CAND_RQ, CAND_F};
  localparam logic [2:0]  LAST_STEP = 3'd4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_CMP   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bias multipliers of ROWS: full pays nothing, quarters one, halves two.
  localparam int unsigned PEN_F = 0;
  localparam int unsigned PEN_Q = 1;
  localparam int unsigned PEN_H = 2;

  function automatic logic [2:0] cand_at(input logic [2:0] step);
    case (step)
      3'd0:    return CMP_ORDER[2:0];
      3'd1:    return CMP_ORDER[5:3];
      3'd2:    return CMP_ORDER[8:6];
      3'd3:    return CMP_ORDER[11:9];
      default: return CMP_ORDER[14:12];
    endcase
  endfunction

  function automatic int unsigned pen_mul(input logic [2:0] cand);
    case (cand)
      CAND_F:           return PEN_F;
      CAND_RQ, CAND_LQ: return PEN_Q;
      default:          return PEN_H;
    endcase
  endfunction

endpackage

// File: rtl/sad_select_if.sv
// Row-input and result-output handshake bundle for sad_select.
interface sad_select_if #(
  parameter int SAD_W = 12,
  parameter int ACC_W = 15
);
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the source holds data stable while valid is
  // high and ready is low, and ready may be asserted without valid.
  logic [5*SAD_W-1:0] sad;
  logic               sad_valid;
  logic               sad_ready;
  logic               best_valid;
  logic               best_ready;
  logic [2:0]         best_idx;
  logic [ACC_W-1:0]   best_sad;
  logic               busy;

  modport master (
    output sad, sad_valid, best_ready,
    input  sad_ready, best_valid, best_idx, best_sad, busy
  );

  modport slave (
    input  sad, sad_valid, best_ready,
    output sad_ready, best_valid, best_idx, best_sad, busy
  );
endinterface

// File: rtl/sad_select_acc.sv
// Five-lane SAD accumulator bank: load overwrites with a zero-extended row,
// add sums a row into the running totals.
module sad_select_acc
  import sad_select_pkg::*;
#(
  parameter int SAD_W = 12,
  parameter int ACC_W = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic                           add,
  input  logic [5*SAD_W-1:0]             sad,
  output logic [N_CAND-1:0][ACC_W-1:0]   acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      for (int k = 0; k < N_CAND; k++) begin
        if (load)
          acc[k] <= ACC_W'(sad[SAD_W*k +: SAD_W]);
        else if (add)
          acc[k] <= acc[k] + ACC_W'(sad[SAD_W*k +: SAD_W]);
      end
    end
  end

endmodule

// File: rtl/sad_select.sv
// Accumulates ROWS five-candidate SAD rows, then picks the minimum over five
// compare cycles. Define SAD_SELECT_BIAS_EN to penalise sub-pel candidates.
module sad_select
  import sad_select_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int SAD_W = 12,
  parameter int ACC_W = SAD_W + $clog2(ROWS)
) (
  input  logic         clk,
  input  logic         rst,
  sad_select_if.slave  bus,
  output state_t       dbg_state
);

  localparam int CNT_W = $clog2(ROWS + 1);
`ifdef SAD_SELECT_BIAS_EN
  localparam int KEY_W = ACC_W + 2;
`else
  localparam int KEY_W = ACC_W;
`endif

  state_t                         state;
  logic [CNT_W-1:0]               row_cnt;
  logic [2:0]                     step;
  logic [2:0]                     best_idx;
  logic [ACC_W-1:0]               best_sad;
  logic [KEY_W-1:0]               best_key;
  logic [N_CAND-1:0][ACC_W-1:0]   acc;
  logic                           accept;
  logic                           last_row;
  logic [2:0]                     cand;
  logic [ACC_W-1:0]               cand_acc;
  logic [KEY_W-1:0]               cand_key;

  assign accept   = bus.sad_valid & bus.sad_ready;
  assign last_row = (state == ST_IDLE) ? (ROWS == 1) : (row_cnt == CNT_W'(ROWS - 1));

  sad_select_acc #(.SAD_W(SAD_W), .ACC_W(ACC_W)) u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (accept && (state == ST_IDLE)),
    .add  (accept && (state == ST_ACCUM)),
    .sad  (bus.sad),
    .acc  (acc)
  );

  assign cand     = cand_at(step);
  assign cand_acc = acc[cand];
`ifdef SAD_SELECT_BIAS_EN
  assign cand_key = KEY_W'(cand_acc) + KEY_W'(pen_mul(cand) * ROWS);
`else
  assign cand_key = cand_acc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      row_cnt  <= '0;
      step     <= '0;
      best_idx <= '0;
      best_sad <= '0;
      best_key <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            row_cnt <= CNT_W'(1);
            step    <= '0;
            state   <= last_row ? ST_CMP : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            row_cnt <= row_cnt + CNT_W'(1);
            if (last_row) begin
              step  <= '0;
              state <= ST_CMP;
            end
          end
        end
        ST_CMP: begin
          // Strict less-than keeps the earlier-visited candidate on ties.
          if (step == 3'd0 || cand_key < best_key) begin
            best_idx <= cand;
            best_sad <= cand_acc;
            best_key <= cand_key;
          end
          if (step == LAST_STEP)
            state <= ST_DONE;
          else
            step <= step + 3'd1;
        end
        default: begin
          if (bus.best_ready)
            state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sad_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign bus.best_valid = (state == ST_DONE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.best_idx   = best_idx;
  assign bus.best_sad   = best_sad;
  assign dbg_state      = state;

endmodule

// File: tb/tb_sad_select.sv
// Self-checking bench for sad_select: block-level scoreboard plus reset,
// latency, tie-break, saturation and handshake scenarios.
module tb_sad_select;
  import sad_select_pkg::*;

  localparam int ROWS  = 8;
  localparam int SAD_W = 12;
  localparam int ACC_W = 15;
  localparam int W     = 3 + ACC_W;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  sad_select_if #(.SAD_W(SAD_W), .ACC_W(ACC_W)) bus ();

  sad_select #(.ROWS(ROWS), .SAD_W(SAD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0]       exp_q[$];
  logic [5*SAD_W-1:0] blk [ROWS];
  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  function automatic logic [5*SAD_W-1:0] pack5(input int f0, f1, f2, f3, f4);
    return {SAD_W'(f4), SAD_W'(f3), SAD_W'(f2), SAD_W'(f1), SAD_W'(f0)};
  endfunction

  function automatic logic [W-1:0] model();
    logic [ACC_W-1:0] acc [5];
    logic [ACC_W+1:0] key [5];
    int rank [5];
    int best;
    rank = '{3, 1, 0, 2, 4};  // lower rank wins a tie: F, RQ, LQ, RH, LH
    for (int k = 0; k < 5; k++) begin
      acc[k] = '0;
      for (int r = 0; r < ROWS; r++)
        acc[k] = acc[k] + ACC_W'(blk[r][SAD_W*k +: SAD_W]);
      key[k] = (ACC_W+2)'(acc[k]);
`ifdef SAD_SELECT_BIAS_EN
      if (k == 1 || k == 3) key[k] = key[k] + (ACC_W+2)'(ROWS);
      if (k == 0 || k == 4) key[k] = key[k] + (ACC_W+2)'(2 * ROWS);
`endif
    end
    best = 0;
    for (int k = 1; k < 5; k++)
      if (key[k] < key[best] || (key[k] == key[best] && rank[k] < rank[best]))
        best = k;
    return {3'(best), acc[best]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_const(input int f0, f1, f2, f3, f4);
    for (int r = 0; r < ROWS; r++) blk[r] = pack5(f0, f1, f2, f3, f4);
  endtask

  task automatic fill_rand(input int maxv);
    for (int r = 0; r < ROWS; r++)
      blk[r] = pack5($urandom_range(0, maxv), $urandom_range(0, maxv),
                     $urandom_range(0, maxv), $urandom_range(0, maxv),
                     $urandom_range(0, maxv));
  endtask

  task automatic drive_row(input logic [5*SAD_W-1:0] d);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.sad       = d;
      bus.sad_valid = 1'b1;
      if (bus.sad_ready) begin
        @(posedge clk);
        return;
      end
    end
  endtask

  // Returns just after the edge accepting the last row; hold_junk keeps
  // sad_valid high with unrelated data through the compare phase.
  task automatic send_block(input bit hold_junk);
    exp_q.push_back(model());
    for (int r = 0; r < ROWS; r++) drive_row(blk[r]);
    #1;
    if (hold_junk) bus.sad = pack5(1, 1, 1, 1, 1);
    else           bus.sad_valid = 1'b0;
  endtask

  // Counts falling edges after the last accept until best_valid; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.best_valid) begin
        lat = c;
        return;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.best_ready = 1'b1;
    bus.sad_valid  = 1'b0;
    @(posedge clk);
    #1 bus.best_ready = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #2;
    if (!rst && bus.best_valid && bus.best_ready) begin
      logic [W-1:0] exp_v;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: unexpected result idx=%0d sad=%0d, no entry queued",
                 bus.best_idx, bus.best_sad);
      end else begin
        exp_v = exp_q.pop_front();
        if ({bus.best_idx, bus.best_sad} !== exp_v)
          $display("FAIL scoreboard: got idx=%0d sad=%0d, expected idx=%0d sad=%0d",
                   bus.best_idx, bus.best_sad, exp_v[W-1:ACC_W], exp_v[ACC_W-1:0]);
        else
          n_pass++;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_total++;
    if ({bus.sad_ready, bus.best_valid, bus.busy} !== 3'b100)
      $display("FAIL reset_flags: ready/valid/busy=%b expected 100",
               {bus.sad_ready, bus.best_valid, bus.busy});
    else n_pass++;
    n_total++;
    if (bus.best_idx !== 3'd0 || bus.best_sad !== '0)
      $display("FAIL reset_best: idx=%0d sad=%0d expected 0/0", bus.best_idx, bus.best_sad);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_IDLE)
      $display("FAIL reset_state: state=%0d expected %0d", dbg_state, ST_IDLE);
    else n_pass++;

    for (int r = 0; r < 3; r++) drive_row(pack5(100, 200, 300, 400, 500));
    @(negedge clk);
    bus.sad_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if ({bus.sad_ready, bus.best_valid, bus.busy} !== 3'b100)
      $display("FAIL midblock_reset: ready/valid/busy=%b expected 100",
               {bus.sad_ready, bus.best_valid, bus.busy});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;

    begin
      int lat;
      fill_const(30, 20, 25, 40, 50);
      send_block(1'b0);
      wait_valid(lat);
      n_total++;
      if (lat !== 6) $display("FAIL reset_fresh_latency: got %0d expected 6", lat);
      else n_pass++;
      release_result();
    end
  endtask

  task automatic test_basic();
    int lat;
    fill_const(20, 15, 10, 15, 20);
    send_block(1'b0);
    wait_valid(lat);
    n_total++;
    if (lat !== 6) $display("FAIL basic_latency: got %0d expected 6", lat);
    else n_pass++;
    n_total++;
    if (bus.best_idx !== 3'd2 || bus.best_sad !== 15'd80)
      $display("FAIL basic_value: idx=%0d sad=%0d expected 2/80", bus.best_idx, bus.best_sad);
    else n_pass++;
    release_result();
  endtask

  task automatic test_subpel();
    int lat;
    fill_const(5, 3, 9, 7, 6);
    send_block(1'b0);
    wait_valid(lat);
    n_total++;
    if (lat !== 6) $display("FAIL subpel_latency: got %0d expected 6", lat);
    else n_pass++;
    n_total++;
    if (bus.best_idx !== 3'd1 || bus.best_sad !== 15'd24)
      $display("FAIL subpel_value: idx=%0d sad=%0d expected 1/24", bus.best_idx, bus.best_sad);
    else n_pass++;
    release_result();
  endtask

  task automatic test_tie();
    int lat;
    int pats [3][5];
    pats = '{'{4, 4, 4, 4, 4}, '{6, 4, 5, 4, 6}, '{3, 9, 9, 9, 3}};
    for (int p = 0; p < 3; p++) begin
      fill_const(pats[p][0], pats[p][1], pats[p][2], pats[p][3], pats[p][4]);
      send_block(1'b0);
      wait_valid(lat);
      n_total++;
      if (lat !== 6) $display("FAIL tie_latency[%0d]: got %0d expected 6", p, lat);
      else n_pass++;
      release_result();
    end
  endtask

  task automatic test_saturation();
    int lat;
    fill_const(4095, 4095, 4095, 4095, 4095);
    send_block(1'b0);
    wait_valid(lat);
    n_total++;
    if (bus.best_idx !== 3'd2 || bus.best_sad !== 15'd32760)
      $display("FAIL saturation: idx=%0d sad=%0d expected 2/32760", bus.best_idx, bus.best_sad);
    else n_pass++;
    release_result();
  endtask

  task automatic test_handshake();
    int lat;
    int bad;
    logic [W-1:0] exp_v;
    fill_const(30, 25, 40, 12, 50);
    send_block(1'b1);
    exp_v = exp_q[exp_q.size()-1];
    wait_valid(lat);
    n_total++;
    if (lat !== 6) $display("FAIL hs_latency_with_junk_valid: got %0d expected 6", lat);
    else n_pass++;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (!bus.best_valid || bus.sad_ready || !bus.busy ||
          {bus.best_idx, bus.best_sad} !== exp_v) bad++;
    end
    n_total++;
    if (bad != 0)
      $display("FAIL hs_hold: %0d unstable cycles, last idx=%0d sad=%0d ready=%b expected idx=%0d sad=%0d ready=0",
               bad, bus.best_idx, bus.best_sad, bus.sad_ready, exp_v[W-1:ACC_W], exp_v[ACC_W-1:0]);
    else n_pass++;
    release_result();
    @(negedge clk);
    n_total++;
    if ({bus.sad_ready, bus.best_valid, bus.busy} !== 3'b100)
      $display("FAIL hs_after_release: ready/valid/busy=%b expected 100",
               {bus.sad_ready, bus.best_valid, bus.busy});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int maxv [4];
    maxv = '{4095, 15, 3, 600};
    for (int b = 0; b < 4; b++) begin
      fill_rand(maxv[b]);
      send_block(1'b0);
      wait_valid(lat);
      n_total++;
      if (lat !== 6) $display("FAIL b2b_latency[%0d]: got %0d expected 6", b, lat);
      else n_pass++;
      release_result();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst            = 1'b1;
    bus.sad        = '0;
    bus.sad_valid  = 1'b0;
    bus.best_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    test_reset();
    test_basic();
    test_subpel();
    test_tie();
    test_saturation();
    test_handshake();
    test_back_to_back();

    repeat (3) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d results still expected, required 0", exp_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
